// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display path: blanking constants, digit
// positions, the BCD digit type and the registered output bundle of the scan driver.
package clock_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] DISP_OFF  = 8'hFF;

    localparam logic [2:0] IDX_SEC1   = 3'd0;
    localparam logic [2:0] IDX_SEC2   = 3'd1;
    localparam logic [2:0] IDX_MIN1   = 3'd2;
    localparam logic [2:0] IDX_MIN2   = 3'd3;
    localparam logic [2:0] IDX_HOUR1  = 3'd4;
    localparam logic [2:0] IDX_HOUR2  = 3'd5;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic [7:0] disp_en;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       frame_done;
    } disp_out_t;

    localparam disp_out_t OUT_RESET = '{
        disp_en:    DISP_OFF,
        seg:        SEG_BLANK,
        dp:         1'b1,
        idx:        3'd0,
        frame_done: 1'b0
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode {a,b,c,d,e,f,g};
// codes 10..15 decode to an unlit digit.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        unique case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode scan driver: per-frame digit snapshot, blanking gap
// at the start of each slot, registered outputs. Optional macro LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
    import clock_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 11,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [7:0]              dispEn,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          idx_q, idx_d;
    logic                loaded_q, loaded_d;
    bcd_t                shadow_q [NUM_DIGITS];
    bcd_t                shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    disp_out_t           out_q, out_d;

    logic       last_tick;
    logic       frame_wrap;
    bcd_t       cur_digit;
    logic [6:0] dec_seg;
    logic [6:0] seg_on;

    assign last_tick  = (tick_q == TICK_W'(SCAN_DIV - 1));
    assign frame_wrap = last_tick && (idx_q == 3'(NUM_DIGITS - 1));
    assign cur_digit  = shadow_q[idx_q];

    bcd_to_seg7 u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        seg_on = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == IDX_HOUR2 && cur_digit == 4'd0)
            seg_on = SEG_BLANK;
`endif
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tick_d      = tick_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        out_d       = OUT_RESET;
        out_d.idx   = idx_q;

        if (en) begin
            tick_d = last_tick ? '0 : tick_q + 1'b1;
            if (last_tick)
                idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;

            // Snapshot lands together with the wrap to position 0, so a frame never tears.
            if (frame_wrap || !loaded_q) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    shadow_d[i] = digits_bcd[4*i +: 4];
                shadow_dp_d = dp_mask;
                loaded_d    = 1'b1;
            end

            out_d.frame_done = frame_wrap;
            if (tick_q >= TICK_W'(BLANK_CYCLES)) begin
                out_d.disp_en = ~(8'h01 << idx_q);
                out_d.seg     = seg_on;
                out_d.dp      = ~shadow_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            tick_q      <= '0;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            shadow_dp_q <= '0;
            // NOTE: the shadow is a small register file, not a RAM, so it takes the reset like any other flop.
            for (int i = 0; i < NUM_DIGITS; i++)
                shadow_q[i] <= '0;
            out_q       <= OUT_RESET;
        end else begin
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            shadow_dp_q <= shadow_dp_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
        end
    end

    assign dispEn     = out_q.disp_en;
    assign seg        = out_q.seg;
    assign dp         = out_q.dp;
    assign digit_idx  = out_q.idx;
    assign frame_done = out_q.frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: a cycle-level reference model
// pushes expected outputs to a scoreboard queue, plus directed slot checks.
module tb_seven_seg_scan_driver;
    import clock_disp_pkg::*;

    localparam int ND  = 6;
    localparam int DIV = 11;
    localparam int BLK = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic [23:0]   digits_bcd;
    logic [5:0]    dp_mask;
    logic [7:0]    dispEn;
    logic [6:0]    seg;
    logic          dp;
    logic [2:0]    digit_idx;
    logic          frame_done;

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits_bcd (digits_bcd),
        .dp_mask    (dp_mask),
        .dispEn     (dispEn),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;

    // reference model state: count of enabled cycles since reset, plus snapshot
    int          pos = 0;
    bit          loaded = 1'b0;
    logic [23:0] snap = '0;
    logic [5:0]  snap_dp = '0;

    disp_out_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        disp_out_t e;
        disp_out_t got;
        int t;
        int i;
        t = pos % DIV;
        i = (pos / DIV) % ND;
        e = '{disp_en: 8'hFF, seg: 7'h7F, dp: 1'b1, idx: 3'd0, frame_done: 1'b0};
        if (!reset) begin
            e.idx = 3'(i);
            if (en) begin
                e.frame_done = (t == DIV - 1) && (i == ND - 1);
                if (t >= BLK) begin
                    e.disp_en = ~(8'h01 << i);
                    e.seg     = seg_ref(snap[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                    if (i == 5 && snap[23:20] == 4'd0)
                        e.seg = 7'h7F;
`endif
                    e.dp      = ~snap_dp[i];
                end
            end
        end
        sb.push_back(e);
        @(posedge clk);
        if (reset) begin
            pos = 0;
            loaded = 1'b0;
            snap = '0;
            snap_dp = '0;
        end else if (en) begin
            if (!loaded || (t == DIV - 1 && i == ND - 1)) begin
                snap = digits_bcd;
                snap_dp = dp_mask;
                loaded = 1'b1;
            end
            pos++;
        end
        #1;
        got = sb.pop_front();
        check("sb_dispEn", 32'(dispEn), 32'(got.disp_en));
        check("sb_seg", 32'(seg), 32'(got.seg));
        check("sb_dp", 32'(dp), 32'(got.dp));
        check("sb_digit_idx", 32'(digit_idx), 32'(got.idx));
        check("sb_frame_done", 32'(frame_done), 32'(got.frame_done));
        if (frame_done === 1'b1)
            fd_seen++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++)
            step();
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        digits_bcd = 24'h123456;
        dp_mask    = 6'b010100;

        // reset held three cycles, then one cycle after release still dark
        run(3);
        check("rst_dispEn", 32'(dispEn), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_idx", 32'(digit_idx), 32'd0);
        reset = 1'b0;
        run(1);
        check("post_rst_dispEn", 32'(dispEn), 32'hFF);
        check("post_rst_fd", 32'(frame_done), 32'd0);

        // scan order: positions show pos 2 (idx0 first ON cycle)
        run(2);
        check("idx0_dispEn", 32'(dispEn), 32'hFE);
        check("idx0_seg", 32'(seg), 32'(7'b0100000));
        check("idx0_dp", 32'(dp), 32'd1);
        fd_seen = 0;
        run(22);
        check("idx2_dispEn", 32'(dispEn), 32'hFB);
        check("idx2_seg", 32'(seg), 32'(7'b1001100));
        check("idx2_dp", 32'(dp), 32'd0);

        // snapshot: inputs cleared mid-frame stay invisible until the next frame
        digits_bcd = 24'h000000;
        run(11);
        check("snap_idx3_seg", 32'(seg), 32'(7'b0000110));
        run(22);
        check("idx5_dispEn", 32'(dispEn), 32'hDF);
        check("idx5_seg", 32'(seg), 32'(7'b1001111));
        run(8);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        run(3);
        check("next_frame_idx0_seg", 32'(seg), 32'(7'b0000001));
        check("fd_once_first_frame", 32'(fd_seen), 32'd1);

        // invalid BCD on sec1 decodes blank while the position is still enabled
        digits_bcd = 24'h00000A;
        fd_seen = 0;
        run(66);
        check("bad_bcd_dispEn", 32'(dispEn), 32'hFE);
        check("bad_bcd_seg", 32'(seg), 32'h7F);
        check("fd_once_per_66", 32'(fd_seen), 32'd1);

        // enable freeze mid-slot at idx 3
        digits_bcd = 24'h123456;
        run(35);
        check("pre_freeze_idx", 32'(digit_idx), 32'd3);
        en = 1'b0;
        run(20);
        check("freeze_dispEn", 32'(dispEn), 32'hFF);
        check("freeze_seg", 32'(seg), 32'h7F);
        check("freeze_idx", 32'(digit_idx), 32'd3);
        en = 1'b1;
        run(1);
        check("resume_dispEn", 32'(dispEn), 32'hF7);
        check("resume_idx", 32'(digit_idx), 32'd3);
        run(6);
        check("resume_next_idx", 32'(digit_idx), 32'd4);
        check("resume_next_blank", 32'(dispEn), 32'hFF);

        // leading hour digit zero
        digits_bcd = 24'h010509;
        run(68);
        check("lz_idx4_dispEn", 32'(dispEn), 32'hEF);
        check("lz_idx4_seg", 32'(seg), 32'(7'b1001111));
        run(11);
        check("lz_idx5_dispEn", 32'(dispEn), 32'hDF);
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_idx5_seg", 32'(seg), 32'h7F);
`else
        check("lz_idx5_seg", 32'(seg), 32'(7'b0000001));
`endif

        // reset mid-frame returns to position 0 with a fresh snapshot
        run(20);
        reset = 1'b1;
        run(2);
        check("midrst_dispEn", 32'(dispEn), 32'hFF);
        check("midrst_idx", 32'(digit_idx), 32'd0);
        reset = 1'b0;
        run(3);
        check("midrst_idx0_dispEn", 32'(dispEn), 32'hFE);
        check("midrst_idx0_seg", 32'(seg), 32'(7'b0000100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
